// File: rtl/uart_tx_mmio_pkg.sv
// rtl/uart_tx_mmio_pkg.sv - register offsets, status bit positions and FSM encoding for the UART transmitter
package uart_tx_mmio_pkg;

  localparam logic [3:0] UART_TXDATA_OFF = 4'h0;
  localparam logic [3:0] UART_STATUS_OFF = 4'h4;

  localparam int STAT_FULL  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_BUSY  = 2;
  localparam int STAT_OVF   = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  function automatic logic [31:0] status_word(input logic full, input logic empty,
                                              input logic busy, input logic ovf);
    logic [31:0] w;
    w = '0;
    w[STAT_FULL]  = full;
    w[STAT_EMPTY] = empty;
    w[STAT_BUSY]  = busy;
    w[STAT_OVF]   = ovf;
    return w;
  endfunction

endpackage

// File: rtl/uart_tx_mmio_sync_fifo.sv
// rtl/uart_tx_mmio_sync_fifo.sv - synchronous FIFO with wrap-bit pointers and registered read data
module uart_tx_mmio_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      rdata <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + PTR_ONE;
      end
      if (do_pop) begin
        rptr  <= rptr + PTR_ONE;
        rdata <= mem[rptr[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// rtl/uart_tx_mmio.sv - memory-mapped 8N1 UART transmitter with TX FIFO and sticky overflow flag
module uart_tx_mmio
  import uart_tx_mmio_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_bus_en,
  input  logic        i_bus_we,
  input  logic [3:0]  i_bus_addr,
  input  logic [31:0] i_bus_wdata,
  output logic [31:0] o_bus_rdata,
  output logic        o_bus_ack,
  output logic        o_tx
);

  localparam int DIV   = CLK_FREQ / BAUD;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV - 1);

  tx_state_e        state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             ovf;

  logic       wr_txdata;
  logic       wr_status;
  logic       fifo_pop;
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_rdata;
  logic       ovf_set;
  logic       ovf_clr;
  logic       busy;
  logic       unused_wdata;

  assign unused_wdata = ^i_bus_wdata[31:8];

  assign wr_txdata = i_bus_en && i_bus_we && (i_bus_addr == UART_TXDATA_OFF);
  assign wr_status = i_bus_en && i_bus_we && (i_bus_addr == UART_STATUS_OFF);
  assign busy      = (state != ST_IDLE);
  assign fifo_pop  = (state == ST_IDLE) && !fifo_empty;
  assign ovf_set   = wr_txdata && fifo_full && !fifo_pop;
  assign ovf_clr   = wr_status && i_bus_wdata[STAT_OVF];

  uart_tx_mmio_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (wr_txdata),
    .wdata (i_bus_wdata[7:0]),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_bus_ack   <= 1'b0;
      o_bus_rdata <= '0;
    end else begin
      o_bus_ack <= i_bus_en;
      if (i_bus_en && !i_bus_we && (i_bus_addr == UART_STATUS_OFF)) begin
        o_bus_rdata <= status_word(fifo_full, fifo_empty, busy, ovf);
      end else begin
        o_bus_rdata <= '0;
      end
    end
  end

  // A set in the same cycle as a clear must not be lost.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ovf <= 1'b0;
    end else if (ovf_set) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

  // o_tx trails the state by one clock, so every line bit still lasts exactly DIV cycles.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      o_tx     <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          o_tx <= 1'b1;
          if (!fifo_empty) begin
            state    <= ST_START;
            baud_cnt <= CNT_LOAD;
          end
        end
        ST_START: begin
          o_tx <= 1'b0;
          if (baud_cnt == '0) begin
            // FIFO read data became valid the cycle after the pop, well before this point.
            shift    <= fifo_rdata;
            bit_idx  <= '0;
            baud_cnt <= CNT_LOAD;
            state    <= ST_DATA;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        ST_DATA: begin
          o_tx <= shift[0];
          if (baud_cnt == '0) begin
            shift    <= {1'b0, shift[7:1]};
            baud_cnt <= CNT_LOAD;
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        ST_STOP: begin
          o_tx <= 1'b1;
          if (baud_cnt == '0) begin
            state <= ST_IDLE;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          o_tx  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb/tb_uart_tx_mmio.sv - scoreboard bench for uart_tx_mmio at DIV = 10
module tb_uart_tx_mmio;

  logic        clk;
  logic        rst;
  logic        bus_en;
  logic        bus_we;
  logic [3:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] o_bus_rdata;
  logic        o_bus_ack;
  logic        o_tx;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_cyc = 0;
  int frames_seen = 0;
  bit mon_en = 1'b0;

  logic [8:0] sb[$];
  int         start_log[$];

  uart_tx_mmio #(
    .CLK_FREQ   (1_000_000),
    .BAUD       (100_000),
    .FIFO_DEPTH (8)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_bus_en    (bus_en),
    .i_bus_we    (bus_we),
    .i_bus_addr  (bus_addr),
    .i_bus_wdata (bus_wdata),
    .o_bus_rdata (o_bus_rdata),
    .o_bus_ack   (o_bus_ack),
    .o_tx        (o_tx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic bus_access(input logic we, input logic [3:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata);
    bus_en    = 1'b1;
    bus_we    = we;
    bus_addr  = addr;
    bus_wdata = wdata;
    @(posedge clk);
    #1;
    last_cyc = cyc;
    check("bus_ack", 32'(o_bus_ack), 32'd1);
    rdata  = o_bus_rdata;
    bus_en = 1'b0;
    bus_we = 1'b0;
  endtask

  task automatic bus_wr(input logic [3:0] addr, input logic [31:0] wdata, input bit expect_tx);
    logic [31:0] dummy;
    if (expect_tx) sb.push_back({1'b0, wdata[7:0]});
    bus_access(1'b1, addr, wdata, dummy);
  endtask

  task automatic bus_rd_check(input string tag, input logic [3:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    bus_access(1'b0, addr, 32'h0, rd);
    check(tag, rd, exp);
  endtask

  task automatic wait_frames(input string tag, input int n, input int limit);
    int k;
    k = 0;
    while (frames_seen < n && k < limit) begin
      @(posedge clk);
      #1;
      k++;
    end
    check(tag, 32'(frames_seen), 32'(n));
  endtask

  task automatic wait_cycle(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Decodes frames from the line at bit centres and scores them against the queue.
  initial begin : monitor
    logic [9:0] bits;
    logic [8:0] exp;
    bit         abort;
    int         t0;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en && !rst && o_tx === 1'b0) begin
        t0 = cyc;
        start_log.push_back(t0);
        abort = 1'b0;
        bits = '0;
        for (int k = 0; k < 10; k++) begin
          if (!abort) begin
            repeat ((k == 0) ? 5 : 10) @(posedge clk);
            #1;
            if (!mon_en || rst) abort = 1'b1;
            else bits[k] = o_tx;
          end
        end
        if (!abort) begin
          check("start_bit", 32'(bits[0]), 32'd0);
          check("stop_bit", 32'(bits[9]), 32'd1);
          exp = (sb.size() > 0) ? sb.pop_front() : 9'h100;
          check("frame_byte", 32'(bits[8:1]), 32'(exp));
          frames_seen++;
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int w0;
    int lows;
    rst       = 1'b1;
    bus_en    = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = 4'h0;
    bus_wdata = 32'h0;

    // T1 reset and decode
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", 32'(o_tx), 32'd1);
    check("rst_ack", 32'(o_bus_ack), 32'd0);
    check("rst_rdata", o_bus_rdata, 32'h0);
    rst = 1'b0;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    check("idle_ack", 32'(o_bus_ack), 32'd0);
    bus_rd_check("t1_status", 4'h4, 32'h2);
    @(posedge clk);
    #1;
    check("t1_ack_drop", 32'(o_bus_ack), 32'd0);
    bus_rd_check("t1_txdata_rd", 4'h0, 32'h0);
    bus_wr(4'h8, 32'h55, 1'b0);
    bus_rd_check("t1_other_rd", 4'h8, 32'h0);
    bus_rd_check("t1_status_again", 4'h4, 32'h2);
    repeat (20) @(posedge clk);
    #1;
    check("t1_no_tx", 32'(frames_seen), 32'd0);

    // T2 single byte
    frames_seen = 0;
    start_log.delete();
    bus_wr(4'h0, 32'h0000_00A5, 1'b1);
    w0 = last_cyc;
    repeat (15) @(posedge clk);
    #1;
    bus_rd_check("t2_busy", 4'h4, 32'h6);
    wait_frames("t2_frames", 1, 300);
    check("t2_latency", 32'((start_log.size() > 0) ? start_log[0] - w0 : -1), 32'd2);
    repeat (10) @(posedge clk);
    #1;
    bus_rd_check("t2_done", 4'h4, 32'h2);

    // T3 back-to-back
    frames_seen = 0;
    start_log.delete();
    bus_wr(4'h0, 32'h11, 1'b1);
    bus_wr(4'h0, 32'h22, 1'b1);
    bus_wr(4'h0, 32'h33, 1'b1);
    wait_frames("t3_frames", 3, 500);
    for (int i = 1; i < 3; i++) begin
      check("t3_gap", 32'((start_log.size() > i) ? start_log[i] - start_log[i-1] : -1), 32'd101);
    end
    repeat (10) @(posedge clk);
    #1;
    bus_rd_check("t3_done", 4'h4, 32'h2);

    // T4 overflow
    frames_seen = 0;
    for (int i = 0; i < 10; i++) begin
      bus_wr(4'h0, 32'(i), i < 9);
    end
    bus_rd_check("t4_ovf_set", 4'h4, 32'hD);
    bus_wr(4'h4, 32'h8, 1'b0);
    bus_rd_check("t4_ovf_clr", 4'h4, 32'h5);
    wait_frames("t4_frames", 9, 1200);
    repeat (10) @(posedge clk);
    #1;
    bus_rd_check("t4_done", 4'h4, 32'h2);

    // T5 push on full in the pop cycle
    frames_seen = 0;
    bus_wr(4'h0, 32'h40, 1'b1);
    w0 = last_cyc;
    for (int i = 1; i < 9; i++) begin
      bus_wr(4'h0, 32'h40 + 32'(i), 1'b1);
    end
    bus_rd_check("t5_full", 4'h4, 32'h5);
    wait_cycle(w0 + 101);
    bus_wr(4'h0, 32'h49, 1'b1);
    bus_rd_check("t5_no_ovf", 4'h4, 32'h5);
    wait_frames("t5_frames", 10, 1300);
    repeat (10) @(posedge clk);
    #1;
    bus_rd_check("t5_done", 4'h4, 32'h2);

    // T6 reset mid-frame
    mon_en = 1'b0;
    bus_wr(4'h0, 32'hF0, 1'b0);
    w0 = last_cyc;
    bus_wr(4'h0, 32'hAA, 1'b0);
    bus_wr(4'h0, 32'h55, 1'b0);
    wait_cycle(w0 + 46);
    check("t6_bit3_low", 32'(o_tx), 32'd0);
    #3;
    rst = 1'b1;
    #1;
    check("t6_async_high", 32'(o_tx), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    bus_rd_check("t6_status", 4'h4, 32'h2);
    lows = 0;
    for (int i = 0; i < 350; i++) begin
      @(posedge clk);
      #1;
      if (o_tx !== 1'b1) lows++;
    end
    check("t6_no_frames", 32'(lows), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
